// File: rtl/iob_counter_down_n.sv
// Loadable down-counter/timer with valid/ready load, registered terminal-count
// pulse and optional auto-reload for periodic ticks.
module iob_counter_down_n #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RST_VAL = 0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              reload_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [DATA_W-1:0] LP_RST_VAL = DATA_W'(RST_VAL);
  localparam logic [DATA_W-1:0] LP_ONE     = DATA_W'(1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] w_count_nxt;
  logic [DATA_W-1:0] r_reload;
  logic [DATA_W-1:0] w_reload_nxt;
  logic              r_done;
  logic              w_done_nxt;

  // Decrement that clamps at zero instead of wrapping to all-ones.
  function automatic logic [DATA_W-1:0] f_sat_dec(input logic [DATA_W-1:0] v);
    return (v == '0) ? '0 : (v - LP_ONE);
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    load_ready_o = (r_state == S_IDLE);
    busy_o       = (r_state == S_RUN);

    if (rst_i) begin
      w_state_nxt  = S_IDLE;
      w_count_nxt  = LP_RST_VAL;
      w_reload_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_valid_i) begin
            w_count_nxt  = load_data_i;
            w_reload_nxt = load_data_i;
            // A zero load is already at terminal count: pulse done, stay idle.
            if (load_data_i == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (en_i) begin
            if (r_count > LP_ONE) begin
              w_count_nxt = f_sat_dec(r_count);
            end else begin
              w_done_nxt = (r_count == LP_ONE);
              if (reload_i && (r_count == LP_ONE)) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = f_sat_dec(r_count);
                w_state_nxt = S_IDLE;
              end
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state  <= S_IDLE;
      r_count  <= LP_RST_VAL;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign data_o = r_count;
  assign done_o = r_done;

endmodule

// File: tb/tb_iob_counter_down_n.sv
// Bench for iob_counter_down_n: directed scenarios plus random traffic, all
// compared against a tick-counting reference model.
module tb_iob_counter_down_n;

  localparam int DW = 8;
  localparam int RV = 5;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          reload = 1'b0;
  logic          lv = 1'b0;
  logic [DW-1:0] ld = '0;
  logic          ready;
  logic [DW-1:0] data;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the count is the loaded period minus enabled ticks seen.
  int m_L;
  int m_t;
  bit m_rst_val;
  bit m_run;
  bit m_done;

  iob_counter_down_n #(.DATA_W(DW), .RST_VAL(RV)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .rst_i        (rst),
    .en_i         (en),
    .reload_i     (reload),
    .load_valid_i (lv),
    .load_data_i  (ld),
    .load_ready_o (ready),
    .data_o       (data),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  function automatic int m_data();
    return m_rst_val ? RV : (m_L - m_t);
  endfunction

  task automatic m_reset();
    m_rst_val = 1'b1;
    m_L       = 0;
    m_t       = 0;
    m_run     = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic m_edge();
    m_done = 1'b0;
    if (rst) begin
      m_reset();
    end else if (!m_run) begin
      if (lv) begin
        m_rst_val = 1'b0;
        m_L       = int'(ld);
        m_t       = 0;
        if (ld == 0) m_done = 1'b1;
        else         m_run  = 1'b1;
      end
    end else if (en) begin
      m_t++;
      if (m_t == m_L) begin
        m_done = 1'b1;
        if (reload) m_t = 0;
        else        m_run = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_data"},  32'(data),  m_data());
    chk({tag, "_ready"}, 32'(ready), int'(!m_run));
    chk({tag, "_busy"},  32'(busy),  int'(m_run));
    chk({tag, "_done"},  32'(done),  int'(m_done));
  endtask

  // One clock: model advances on the rising edge, outputs sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    int exp_os[4];
    int exp_ar[13];
    int exp_en[5];
    bit pat_en[5];

    m_reset();
    #1 arst_n = 1'b0;
    #2;
    chk("rst_data_const", 32'(data), RV);
    chk_all("rst");
    @(negedge clk);
    arst_n = 1'b1;
    cyc(); chk_all("rst_hold");
    cyc(); chk_all("rst_hold");

    // One-shot load of 3.
    ld = 8'd3; lv = 1'b1; en = 1'b1;
    exp_os = '{3, 2, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cyc();
      lv = 1'b0;
      chk("oneshot_data", 32'(data), exp_os[i]);
      chk("oneshot_done", 32'(done), int'(i == 3));
      chk_all("oneshot");
    end
    chk("oneshot_end_ready", 32'(ready), 1);

    // Back-to-back load in the done cycle.
    ld = 8'd2; lv = 1'b1;
    cyc(); lv = 1'b0;
    chk("b2b_data", 32'(data), 2);
    chk_all("b2b");
    cyc(); chk_all("b2b");
    cyc(); chk_all("b2b");
    chk("b2b_done", 32'(done), 1);

    // Auto-reload with period 4.
    ld = 8'd4; lv = 1'b1; reload = 1'b1;
    exp_ar = '{4, 3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};
    for (int i = 0; i < 13; i++) begin
      cyc();
      lv = 1'b0;
      chk("reload_data", 32'(data), exp_ar[i]);
      chk("reload_done", 32'(done), int'(i != 0 && (i % 4) == 0));
      chk_all("reload");
    end
    rst = 1'b1; reload = 1'b0;
    cyc(); rst = 1'b0;
    chk("reload_abort_data", 32'(data), RV);
    chk_all("reload_abort");

    // Enable gating.
    ld = 8'd5; lv = 1'b1;
    cyc(); lv = 1'b0;
    chk("gate_load", 32'(data), 5);
    pat_en = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_en = '{4, 4, 4, 3, 2};
    for (int i = 0; i < 5; i++) begin
      en = pat_en[i];
      cyc();
      chk("gate_data", 32'(data), exp_en[i]);
      chk("gate_done", 32'(done), 0);
      chk_all("gate");
    end
    rst = 1'b1;
    cyc(); rst = 1'b0; en = 1'b1;
    chk_all("gate_clear");

    // Ignored load during RUN, then synchronous abort.
    ld = 8'd10; lv = 1'b1;
    cyc();
    chk("ign_load", 32'(data), 10);
    ld = 8'd2;
    for (int i = 0; i < 4; i++) begin
      chk("ign_ready", 32'(ready), 0);
      cyc();
      chk("ign_data", 32'(data), 9 - i);
      chk_all("ign");
    end
    lv = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    chk("abort_data", 32'(data), RV);
    chk("abort_done", 32'(done), 0);
    chk_all("abort");

    // Zero load.
    ld = 8'd0; lv = 1'b1;
    cyc(); lv = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk_all("zero");
    cyc(); chk_all("zero_after");

    // Async reset mid-run.
    ld = 8'd7; lv = 1'b1;
    cyc(); lv = 1'b0;
    cyc(); cyc(); cyc();
    chk("arst_pre", 32'(data), 4);
    #2 arst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_data", 32'(data), RV);
    chk("arst_busy", 32'(busy), 0);
    chk_all("arst");
    @(negedge clk);
    arst_n = 1'b1;
    cyc(); chk_all("arst_rel");

    // Maximum load value.
    ld = 8'd255; lv = 1'b1; en = 1'b0;
    cyc(); lv = 1'b0;
    chk("max_data", 32'(data), 255);
    chk_all("max");
    en = 1'b1;
    cyc(); chk("max_dec", 32'(data), 254);
    rst = 1'b1;
    cyc(); rst = 1'b0;
    chk_all("max_clear");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      lv     = ($urandom_range(0, 3) == 0);
      ld     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(0, 6));
      en     = ($urandom_range(0, 3) != 0);
      reload = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 49) == 0);
      cyc();
      chk_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
